// File: rtl/serial_nibble_loader.sv
// serial_nibble_loader: receives start/4-data/parity/stop serial frames and strobes good nibbles out
module serial_nibble_loader #(
  parameter int BIT_CYCLES = 8,
  parameter bit PARITY_ODD = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Sin,
  output logic [3:0] Outp,
  output logic       Load,
  output logic       Busy,
  output logic       Perr,
  output logic       Ferr
);
  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] H_M1 = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0] B_M1 = CW'(BIT_CYCLES - 1);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;
  logic          s1_q, s2_q, sin_s;
  logic [2:0]    st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic [3:0]    outp_q, outp_d;
  logic          load_q, load_d, perr_q, perr_d, ferr_q, ferr_d;
  logic          done, par_ok;
  assign sin_s  = s2_q;
  assign done   = cnt_q == ((st_q == START) ? H_M1 : B_M1);
  assign par_ok = (^{sh_q, par_q}) == PARITY_ODD;
  assign Outp   = outp_q;
  assign Load   = load_q;
  assign Perr   = perr_q;
  assign Ferr   = ferr_q;
  assign Busy   = st_q != IDLE;
  // Next-state: the start check lands mid start bit, each later sample one bit period apart
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    sh_d   = sh_q;
    par_d  = par_q;
    outp_d = outp_q;
    load_d = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        st_d  = sin_s ? IDLE : START;
      end
      START: begin
        cnt_d = done ? '0 : cnt_q + 1'b1;
        idx_d = '0;
        if (done) st_d = sin_s ? IDLE : DATA;
      end
      DATA: begin
        cnt_d = done ? '0 : cnt_q + 1'b1;
        if (done) begin
          sh_d  = {sin_s, sh_q[3:1]};
          idx_d = idx_q + 3'd1;
          st_d  = (idx_q == 3'd3) ? PARITY : DATA;
        end
      end
      PARITY: begin
        cnt_d = done ? '0 : cnt_q + 1'b1;
        if (done) begin
          par_d = sin_s;
          st_d  = STOP;
        end
      end
      STOP: begin
        cnt_d = done ? '0 : cnt_q + 1'b1;
        if (done) begin
          load_d = sin_s & par_ok;
          outp_d = (sin_s & par_ok) ? sh_q : outp_q;
          perr_d = ~par_ok;
          ferr_d = ~sin_s;
          st_d   = sin_s ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: st_d = sin_s ? IDLE : WAIT_IDLE;
      default:   st_d = IDLE;
    endcase
  end
  // State, two-flop line synchronizer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      st_q   <= IDLE;
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      outp_q <= '0;
      load_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s1_q   <= Sin;
      s2_q   <= s1_q;
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      outp_q <= outp_d;
      load_q <= load_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  end
endmodule

// File: tb/tb_serial_nibble_loader.sv
// tb_serial_nibble_loader: directed frames with a scoreboard of expected Load/Perr/Ferr events
module tb_serial_nibble_loader;
  localparam int BC = 8;
  localparam logic [2:0] K_LOAD = 3'b001;
  localparam logic [2:0] K_PERR = 3'b010;
  localparam logic [2:0] K_FERR = 3'b100;
  typedef struct {
    logic [2:0] kind;
    logic [3:0] outp;
    int         cyc;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sin = 1'b1;
  logic [3:0] outp;
  logic       load, busy, perr, ferr;
  logic [3:0] dreg;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       q[$];
  serial_nibble_loader #(.BIT_CYCLES(BC), .PARITY_ODD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .Sin(sin), .Outp(outp),
    .Load(load), .Busy(busy), .Perr(perr), .Ferr(ferr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst_n) dreg <= !rst_n ? 4'h0 : (load ? outp : dreg);
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  // Scoreboard monitor: every strobe must match the oldest expected event, its Outp and cycle
  always @(negedge clk) begin
    if (rst_n && (load || perr || ferr)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got ferr/perr/load=%b outp=%h at cyc %0d, none expected", {ferr, perr, load}, outp, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if ({ferr, perr, load} !== e.kind || outp !== e.outp || cyc != e.cyc) begin
          errors++;
          $display("FAIL event: got kind=%b outp=%h cyc=%0d expected kind=%b outp=%h cyc=%0d", {ferr, perr, load}, outp, cyc, e.kind, e.outp, e.cyc);
        end
      end
    end
  end
  // Drives one frame from a negedge; E0 is the following posedge
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input logic [2:0] kind, input logic [3:0] eo, input bit chk_busy);
    logic [6:0] w;
    int e0;
    w = {s, p, d, 1'b0};
    e0 = cyc + 1;
    if (kind != 3'b000) q.push_back('{kind, eo, e0 + 54});
    for (int n = 0; n < 7 * BC; n++) begin
      sin = w[n / BC];
      @(negedge clk);
      if (chk_busy) chk($sformatf("busy_rel%0d", cyc - e0), busy, (cyc - e0 >= 2 && cyc - e0 <= 53));
    end
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_outp", outp, 4'h0);
    chk("rst_flags", {load, busy, perr, ferr}, 4'b0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(4'hB, 1'b0, 1'b1, K_LOAD, 4'hB, 1'b1);
    chk("downstream_reg", dreg, 4'hB);
    repeat (5) @(negedge clk);
    send_frame(4'h6, 1'b0, 1'b1, K_PERR, 4'hB, 1'b0);
    repeat (5) @(negedge clk);
    chk("outp_held_perr", outp, 4'hB);
    send_frame(4'h9, 1'b1, 1'b0, K_FERR, 4'hB, 1'b0);
    repeat (20) @(negedge clk);
    chk("busy_wait_idle", busy, 1'b1);
    sin = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    chk("busy_ek", busy, 1'b1);
    @(negedge clk);
    chk("busy_ek1", busy, 1'b1);
    @(negedge clk);
    chk("busy_ek2", busy, 1'b0);
    chk("ferr_cycle_ref", cyc, k + 2);
    repeat (5) @(negedge clk);
    send_frame(4'h9, 1'b0, 1'b0, K_FERR | K_PERR, 4'hB, 1'b0);
    repeat (4) @(negedge clk);
    sin = 1'b1;
    repeat (6) @(negedge clk);
    chk("outp_held_ferr", outp, 4'hB);
    sin = 1'b0;
    repeat (2) @(negedge clk);
    sin = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy_e4", busy, 1'b1);
    @(negedge clk);
    chk("glitch_busy_e5", busy, 1'b1);
    @(negedge clk);
    chk("glitch_busy_e6", busy, 1'b0);
    repeat (5) @(negedge clk);
    sin = 1'b0;
    repeat (2 * BC) @(negedge clk);
    sin = 1'b1;
    repeat (BC) @(negedge clk);
    sin = 1'b0;
    repeat (BC / 2) @(negedge clk);
    chk("busy_mid_frame", busy, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outp", outp, 4'h0);
    chk("async_rst_flags", {load, busy, perr, ferr}, 4'b0000);
    sin = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_outp", outp, 4'h0);
    chk("post_rst_busy", busy, 1'b0);
    send_frame(4'h5, 1'b1, 1'b1, K_LOAD, 4'h5, 1'b0);
    repeat (3) @(negedge clk);
    send_frame(4'h3, 1'b1, 1'b1, K_LOAD, 4'h3, 1'b0);
    send_frame(4'hC, 1'b1, 1'b1, K_LOAD, 4'hC, 1'b0);
    sin = 1'b1;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    chk("pending_events", q.size(), 0);
    chk("final_outp", outp, 4'hC);
    chk("final_dreg", dreg, 4'hC);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
